qam_symbol_scheduler: RTL and testbench

Sequences the QAM mapper. Accepts a byte stream over a valid/ready handshake and slices each byte into per-symbol bit groups for the selected modulation order. Emits one symbol slot per programmable symbol-rate strobe and groups symbols into fixed-length frames. The modulation mode can change only at frame boundaries. Sits between the packet/byte source and the mapper bank (2/4/16-QAM mappers selected by sym_mode).

---
 rtl/qam_pkg.sv | 30 +++
 rtl/qam_rate_gen.sv | 29 ++
 rtl/qam_symbol_scheduler.sv | 113 +++++++++++
 tb/tb_qam_symbol_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol path: mode encodings, symbol width,
// scheduler states and the bits-per-symbol helper.
package qam_pkg;

   localparam int SYM_BITS_W = 4;

   localparam logic [1:0] MODE_BPSK  = 2'd0;
   localparam logic [1:0] MODE_QPSK  = 2'd1;
   localparam logic [1:0] MODE_16QAM = 2'd2;
   localparam logic [1:0] MODE_RSVD  = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic [3:0] bits_per_sym(input logic [1:0] mode);
      case (mode)
         MODE_QPSK:  return 4'd2;
         MODE_16QAM: return 4'd4;
         default:    return 4'd1;
      endcase
   endfunction

   // The reserved encoding runs as BPSK so the mapper never sees it.
   function automatic logic [1:0] norm_mode(input logic [1:0] mode);
      return (mode == MODE_RSVD) ? MODE_BPSK : mode;
   endfunction

endpackage

// File: rtl/qam_rate_gen.sv
// Programmable strobe generator: one strobe every div+1 enabled cycles.
module qam_rate_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             strobe
);

   logic [DIV_W-1:0] count;

   // Compare with >= so a live reduction of div wraps immediately instead of
   // running the counter all the way around.
   assign strobe = en && (count >= div);

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and active-low; it only acts on a clock edge.
      if (!rst || clr) begin
         count <= '0;
      end else if (en) begin
         // NOTE: sequential state uses non-blocking assignments only.
         count <= strobe ? '0 : count + DIV_W'(1);
      end
   end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// Slices a valid/ready byte stream into LSB-first QAM symbols, one per rate
// strobe, grouped into FRAME_SYMS-symbol frames with per-frame mode latching.
module qam_symbol_scheduler
   import qam_pkg::*;
#(
   parameter int FRAME_SYMS = 64,
   parameter int DIV_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [1:0]            cfg_mode,
   input  logic [DIV_W-1:0]      cfg_div,
   input  logic [7:0]            s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [SYM_BITS_W-1:0] sym_bits,
   output logic [1:0]            sym_mode,
   output logic                  sym_valid,
   output logic                  frame_start,
   output logic                  underflow,
   output logic                  busy
);

   localparam int CNT_W = $clog2(FRAME_SYMS);

   state_e                  state, state_nxt;
   logic [1:0]              mode_q;
   logic [CNT_W-1:0]        sym_cnt;
   logic [7:0]              shreg, hold;
   logic [3:0]              bits_left, bps;
   logic                    hold_valid, hold_valid_nxt;
   logic                    strobe, accept, emit, load_hold, frame_end;
   logic [SYM_BITS_W-1:0]   sym_src;

   qam_rate_gen #(.DIV_W(DIV_W)) u_rate (
      .clk    (clk),
      .rst    (rst),
      .en     (state == ST_RUN),
      .clr    (state == ST_IDLE),
      .div    (cfg_div),
      .strobe (strobe)
   );

   always_comb begin
      // NOTE: combinational logic uses blocking assignments, each signal
      // defaulted first so no latch is inferred.
      bps            = bits_per_sym(mode_q);
      accept         = s_valid && s_ready;
      load_hold      = strobe && (bits_left == 4'd0) && hold_valid;
      emit           = strobe && ((bits_left != 4'd0) || hold_valid);
      sym_src        = (bits_left != 4'd0) ? shreg[3:0] : hold[3:0];
      frame_end      = emit && (sym_cnt == CNT_W'(FRAME_SYMS - 1));
      hold_valid_nxt = accept ? 1'b1 : (load_hold ? 1'b0 : hold_valid);
      state_nxt      = state;
      case (state)
         ST_IDLE: if (enable) state_nxt = ST_RUN;
         ST_RUN:  if (frame_end && !enable) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         mode_q      <= MODE_BPSK;
         sym_cnt     <= '0;
         shreg       <= '0;
         bits_left   <= '0;
         hold        <= '0;
         hold_valid  <= 1'b0;
         s_ready     <= 1'b0;
         sym_bits    <= '0;
         sym_mode    <= '0;
         sym_valid   <= 1'b0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold_valid  <= hold_valid_nxt;
         s_ready     <= (state_nxt == ST_RUN) && !hold_valid_nxt;
         sym_valid   <= emit;
         frame_start <= emit && (sym_cnt == '0);
         underflow   <= strobe && !emit;

         if (accept) hold <= s_data;

         if (emit) begin
            sym_bits <= sym_src & ~(4'hF << bps);
            sym_mode <= mode_q;
            sym_cnt  <= frame_end ? '0 : sym_cnt + CNT_W'(1);
            if (bits_left != 4'd0) begin
               shreg     <= shreg >> bps;
               bits_left <= bits_left - bps;
            end else begin
               shreg     <= hold >> bps;
               bits_left <= 4'd8 - bps;
            end
         end

         // Mode only changes when a frame starts.
         if (state == ST_IDLE && enable) begin
            mode_q  <= norm_mode(cfg_mode);
            sym_cnt <= '0;
         end else if (frame_end && enable) begin
            mode_q  <= norm_mode(cfg_mode);
         end
      end
   end

   assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Self-checking bench for qam_symbol_scheduler: vector table plus hand-written
// sequences, with a symbol scoreboard checked on the falling clock edge.
module tb_qam_symbol_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  cfg_mode = 2'd0;
   logic [15:0] cfg_div = 16'd0;
   logic [7:0]  s_data = 8'd0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [3:0]  sym_bits;
   logic [1:0]  sym_mode;
   logic        sym_valid, frame_start, underflow, busy;

   qam_symbol_scheduler #(.FRAME_SYMS(64), .DIV_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .cfg_mode(cfg_mode),
      .cfg_div(cfg_div), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .sym_bits(sym_bits), .sym_mode(sym_mode),
      .sym_valid(sym_valid), .frame_start(frame_start),
      .underflow(underflow), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] bits;
      logic [1:0] mode;
      logic       fs;
   } exp_t;

   typedef struct {
      logic [1:0]       mode;
      logic [15:0]      div;
      int               nbytes;
      logic [1:0][7:0]  data;
      logic [15:0][3:0] exp;
      logic [1:0]       exp_mode;
   } vec_t;

   exp_t sb[$];
   int   total = 0, bad = 0;
   int   sym_seen = 0, uf_seen = 0, exp_cnt = 0, cyc = 0;
   int   prev_cyc = 0, exp_gap = 0, rdy_toggles = 0;
   bit   have_prev = 1'b0;
   logic prev_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Output monitor: every emitted symbol is popped from the scoreboard.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst === 1'b1) begin
         if (s_ready !== prev_rdy) rdy_toggles++;
         prev_rdy = s_ready;
         if (underflow === 1'b1) uf_seen++;
         if (sym_valid === 1'b1) begin
            sym_seen++;
            check("sym_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("sym_bits", sym_bits, e.bits);
               check("sym_mode", sym_mode, e.mode);
               check("frame_start", frame_start, e.fs);
            end
            if (exp_gap != 0 && have_prev) check("sym_gap", cyc - prev_cyc, exp_gap);
            have_prev = 1'b1;
            prev_cyc  = cyc;
         end
      end
   end

   function automatic int tb_bps(input logic [1:0] m);
      return (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
   endfunction

   task automatic push_exp(input logic [3:0] bits, input logic [1:0] m);
      exp_t e;
      e.bits = bits;
      e.mode = m;
      e.fs   = (exp_cnt == 0);
      sb.push_back(e);
      exp_cnt = (exp_cnt + 1) % 64;
   endtask

   task automatic push_byte(input logic [7:0] b, input logic [1:0] m);
      int bps = tb_bps(m);
      for (int i = 0; i < 8 / bps; i++)
         push_exp(4'((b >> (i * bps)) & ((8'd1 << bps) - 8'd1)), (m == 2'd3) ? 2'd0 : m);
   endtask

   // Called away from the rising edge; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      s_data  = b;
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("send_accept", s_ready, 1);
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic wait_syms(input string name, input int target, input int budget);
      int n = 0;
      while (sym_seen < target && n < budget) begin
         @(negedge clk);
         #1 n++;
      end
      check(name, sym_seen, target);
   endtask

   // Leaves rst low at a falling edge with the scoreboard flushed.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; enable = 1'b0; s_valid = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      exp_cnt = 0; sym_seen = 0; uf_seen = 0; have_prev = 1'b0; rdy_toggles = 0;
      @(negedge clk);
   endtask

   vec_t vecs[5];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t v;
      int   n, idx, uf_base;

      vecs[0] = '{mode:2'd1, div:16'd3, nbytes:1, data:16'h00B4, exp:64'h2310,     exp_mode:2'd1};
      vecs[1] = '{mode:2'd2, div:16'd0, nbytes:2, data:16'h5AB4, exp:64'h5AB4,     exp_mode:2'd2};
      vecs[2] = '{mode:2'd0, div:16'd1, nbytes:1, data:16'h00B4, exp:64'h10110100, exp_mode:2'd0};
      vecs[3] = '{mode:2'd3, div:16'd2, nbytes:1, data:16'h005A, exp:64'h01011010, exp_mode:2'd0};
      vecs[4] = '{mode:2'd1, div:16'd0, nbytes:2, data:16'hC31E, exp:64'h30030132, exp_mode:2'd1};

      // Reset held with traffic and enable asserted.
      s_valid = 1'b1; s_data = 8'hAA; enable = 1'b1; cfg_mode = 2'd1;
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs", {s_ready, sym_bits, sym_mode, sym_valid, frame_start, underflow, busy}, 0);
      end

      // Vector table: one configuration and one or two bytes per record.
      for (int t = 0; t < 5; t++) begin
         v = vecs[t];
         do_reset();
         cfg_mode = v.mode; cfg_div = v.div; exp_gap = int'(v.div) + 1;
         enable = 1'b1; rst = 1'b1;
         n = 8 / tb_bps(v.mode);
         for (int j = 0; j < v.nbytes; j++) begin
            for (int i = 0; i < n; i++) push_exp(v.exp[j * n + i], v.exp_mode);
            send_byte(v.data[j]);
         end
         wait_syms("vec_sym_count", v.nbytes * n, 300);
         repeat (2 * (int'(v.div) + 1)) @(negedge clk);
         #1;
         idx = v.nbytes * n - 1;
         check("vec_hold_bits", sym_bits, v.exp[idx]);
         check("vec_hold_mode", sym_mode, v.exp_mode);
         check("vec_busy", busy, 1);
         if (v.nbytes == 2) check("vec_ready_toggles", rdy_toggles >= 2, 1);
      end

      // Underflow cadence with no data: first strobe, then every div+1 cycles.
      do_reset();
      cfg_mode = 2'd1; cfg_div = 16'd3; exp_gap = 0; enable = 1'b1; rst = 1'b1;
      n = 0;
      while (underflow !== 1'b1 && n < 50) begin
         @(negedge clk);
         #1 n++;
         if (n == 1) begin
            check("run_busy", busy, 1);
            check("run_ready", s_ready, 1);
         end
      end
      check("uf_first_latency", n, 5);
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            #1 n++;
         end while (underflow !== 1'b1 && n < 50);
         check("uf_period", n, 4);
      end

      // Mode change mid-frame takes effect only at the next frame.
      do_reset();
      cfg_mode = 2'd0; cfg_div = 16'd1; exp_gap = 2; enable = 1'b1; rst = 1'b1;
      fork
         begin
            for (int k = 0; k < 9; k++) begin
               logic [7:0] b = 8'($urandom);
               push_byte(b, (k < 8) ? 2'd0 : 2'd1);
               send_byte(b);
            end
         end
         begin
            int w = 0;
            while (sym_seen < 11 && w < 500) begin
               @(negedge clk);
               #1 w++;
            end
            cfg_mode = 2'd1;
         end
      join
      wait_syms("frame_sym_count", 68, 300);
      check("frame2_mode", sym_mode, 1);

      // Enable dropped mid-frame: the frame completes, then IDLE.
      do_reset();
      cfg_mode = 2'd1; cfg_div = 16'd0; exp_gap = 0; enable = 1'b1; rst = 1'b1;
      uf_base = 0;
      fork
         begin
            for (int k = 0; k < 16; k++) begin
               logic [7:0] b = 8'($urandom);
               if (k == 8) repeat (12) @(negedge clk);
               push_byte(b, 2'd1);
               send_byte(b);
            end
         end
         begin
            int w = 0;
            while (sym_seen < 20 && w < 500) begin
               @(negedge clk);
               #1 w++;
            end
            enable = 1'b0;
            uf_base = uf_seen;
         end
      join
      wait_syms("drop_sym_count", 64, 400);
      check("drop_busy", busy, 0);
      check("drop_ready", s_ready, 0);
      check("drop_underflow_slots", (uf_seen - uf_base) > 0, 1);
      s_data = 8'h77; s_valid = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("idle_ready", s_ready, 0);
      check("idle_busy", busy, 0);
      check("idle_no_syms", sym_seen, 64);
      s_valid = 1'b0;

      // Reset mid-frame with a byte held: old data must not reappear.
      do_reset();
      cfg_mode = 2'd1; cfg_div = 16'd5; exp_gap = 0; enable = 1'b1; rst = 1'b1;
      push_byte(8'hA5, 2'd1);
      send_byte(8'hA5);
      push_byte(8'h3C, 2'd1);
      send_byte(8'h3C);
      @(negedge clk);
      #1 check("pre_reset_syms", sym_seen, 1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      exp_cnt = 0; sym_seen = 0; have_prev = 1'b0;
      check("mid_reset_ready", s_ready, 0);
      check("mid_reset_bits", sym_bits, 0);
      check("mid_reset_mode", sym_mode, 0);
      check("mid_reset_valid", sym_valid, 0);
      check("mid_reset_fs", frame_start, 0);
      check("mid_reset_uf", underflow, 0);
      check("mid_reset_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      push_byte(8'h1E, 2'd1);
      send_byte(8'h1E);
      wait_syms("post_reset_syms", 4, 200);
      repeat (4) @(negedge clk);
      #1 check("post_reset_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
